// File: rtl/clk_rec_ctrl.sv
// Bit-clock recovery sequencer: acquires the bit period from edge intervals,
// tracks it, supervises lock and drives period / phase-realign pulses to the NCO.
module clk_rec_ctrl #(
    parameter int unsigned W             = 32,
    parameter int unsigned INIT_PERIOD   = 801,
    parameter int unsigned ACQ_EDGES     = 16,
    parameter int unsigned LOCK_EDGES    = 256,
    parameter int unsigned TOL_SHIFT     = 3,
    parameter int unsigned TIMEOUT_SHIFT = 4
) (
    input  logic         clk_300M,
    input  logic         rst,
    input  logic         enable,
    input  logic         edge_valid,
    input  logic [W-1:0] interval,
    output logic [W-1:0] period,
    output logic         period_upd,
    output logic         phase_sync,
    output logic         locked,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        LOCK  = 2'd3
    } state_t;

    localparam int unsigned EW = $clog2(ACQ_EDGES + 1);
    localparam int unsigned GW = $clog2(LOCK_EDGES + 1);
    localparam int unsigned IW = W + TIMEOUT_SHIFT;

    localparam logic [W-1:0]  PERIOD_INIT = W'(INIT_PERIOD);
    localparam logic [W-1:0]  PERIOD_ONE  = W'(1);
    localparam logic [EW-1:0] ACQ_LAST    = EW'(ACQ_EDGES - 1);
    localparam logic [EW-1:0] EDGE_ONE    = EW'(1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_EDGES - 1);
    localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
    localparam logic [IW-1:0] IDLE_ONE    = IW'(1);

    state_t        cur_state, nxt_state;
    logic [W-1:0]  period_nxt;
    logic          period_upd_nxt, phase_sync_nxt;
    logic [EW-1:0] edge_cnt, edge_cnt_nxt;
    logic [GW-1:0] good_cnt, good_cnt_nxt;
    logic [IW-1:0] idle_cnt, idle_cnt_nxt;

    logic          edge_ok, is_short, is_consistent;
    logic [W-1:0]  tol, period_inc;
    logic [W:0]    win_lo, win_hi, interval_ext;
    logic [IW-1:0] idle_inc, idle_limit;

    // Zero-length intervals are measurement artefacts and never count as edges.
    assign edge_ok = edge_valid && (interval != '0);

    // Acceptance window is compared one bit wider so period+tol cannot wrap.
    assign tol           = period >> TOL_SHIFT;
    assign win_lo        = {1'b0, period} - {1'b0, tol};
    assign win_hi        = {1'b0, period} + {1'b0, tol};
    assign interval_ext  = {1'b0, interval};
    assign is_short      = interval_ext < win_lo;
    assign is_consistent = !is_short && (interval_ext <= win_hi);

    assign period_inc = (period == '1) ? period : period + PERIOD_ONE;
    assign idle_inc   = (idle_cnt == '1) ? idle_cnt : idle_cnt + IDLE_ONE;
    assign idle_limit = {{TIMEOUT_SHIFT{1'b0}}, period} << TIMEOUT_SHIFT;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nxt_state      = cur_state;
        period_nxt     = period;
        period_upd_nxt = 1'b0;
        phase_sync_nxt = 1'b0;
        edge_cnt_nxt   = edge_cnt;
        good_cnt_nxt   = good_cnt;
        idle_cnt_nxt   = idle_cnt;

        if (!enable) begin
            nxt_state    = IDLE;
            edge_cnt_nxt = '0;
            good_cnt_nxt = '0;
            idle_cnt_nxt = '0;
        end else if (cur_state == IDLE) begin
            nxt_state    = ACQ;
            period_nxt   = PERIOD_INIT;
            edge_cnt_nxt = '0;
            good_cnt_nxt = '0;
            idle_cnt_nxt = '0;
        end else if (edge_ok) begin
            idle_cnt_nxt = '0;
            case (cur_state)
                ACQ: begin
                    if (interval < period) begin
                        period_nxt     = interval;
                        period_upd_nxt = 1'b1;
                    end
                    if (edge_cnt == ACQ_LAST) begin
                        nxt_state    = TRACK;
                        edge_cnt_nxt = '0;
                        good_cnt_nxt = '0;
                    end else begin
                        edge_cnt_nxt = edge_cnt + EDGE_ONE;
                    end
                end
                TRACK, LOCK: begin
                    if (is_short) begin
                        nxt_state      = TRACK;
                        period_nxt     = interval;
                        period_upd_nxt = 1'b1;
                        good_cnt_nxt   = '0;
                    end else if (is_consistent) begin
                        phase_sync_nxt = 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            good_cnt_nxt = '0;
                            if (cur_state == TRACK) begin
                                nxt_state = LOCK;
                            end else begin
                                // Lock probe: nudge the period up to test that lock still holds.
                                period_nxt     = period_inc;
                                period_upd_nxt = 1'b1;
                            end
                        end else begin
                            good_cnt_nxt = good_cnt + GOOD_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end else if (idle_inc >= idle_limit) begin
            nxt_state    = ACQ;
            period_nxt   = PERIOD_INIT;
            edge_cnt_nxt = '0;
            good_cnt_nxt = '0;
            idle_cnt_nxt = '0;
        end else begin
            idle_cnt_nxt = idle_inc;
        end
    end

    always_ff @(posedge clk_300M) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cur_state  <= IDLE;
            period     <= PERIOD_INIT;
            period_upd <= 1'b0;
            phase_sync <= 1'b0;
            locked     <= 1'b0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            cur_state  <= nxt_state;
            period     <= period_nxt;
            period_upd <= period_upd_nxt;
            phase_sync <= phase_sync_nxt;
            locked     <= (nxt_state == LOCK);
            edge_cnt   <= edge_cnt_nxt;
            good_cnt   <= good_cnt_nxt;
            idle_cnt   <= idle_cnt_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_clk_rec_ctrl.sv
// Self-checking bench for clk_rec_ctrl: a rule-level reference model compared every
// cycle, plus directed scenarios with hand-computed expected values.
module tb_clk_rec_ctrl;

    localparam int W         = 32;
    localparam int INIT_P    = 801;
    localparam int ACQ_N     = 4;
    localparam int LOCK_N    = 8;
    localparam int S_IDLE    = 0;
    localparam int S_ACQ     = 1;
    localparam int S_TRACK   = 2;
    localparam int S_LOCK    = 3;
    localparam longint PMAX  = 64'h0000_0000_FFFF_FFFF;

    logic         clk_300M = 1'b0;
    logic         rst;
    logic         enable;
    logic         edge_valid;
    logic [W-1:0] interval;
    logic [W-1:0] period;
    logic         period_upd;
    logic         phase_sync;
    logic         locked;
    logic [1:0]   state;

    clk_rec_ctrl #(
        .W            (W),
        .INIT_PERIOD  (INIT_P),
        .ACQ_EDGES    (ACQ_N),
        .LOCK_EDGES   (LOCK_N),
        .TOL_SHIFT    (3),
        .TIMEOUT_SHIFT(4)
    ) dut (
        .clk_300M  (clk_300M),
        .rst       (rst),
        .enable    (enable),
        .edge_valid(edge_valid),
        .interval  (interval),
        .period    (period),
        .period_upd(period_upd),
        .phase_sync(phase_sync),
        .locked    (locked),
        .state     (state)
    );

    always #2 clk_300M = ~clk_300M;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int upd_cnt  = 0;
    int ps_cnt   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the rules applied to plain integers on each rising edge.
    int     m_state;
    longint m_period;
    bit     m_upd, m_ps;
    int     m_edges, m_good;
    longint m_idle;

    task automatic model_step();
        bit     ev;
        longint iv, p, tol;
        ev    = edge_valid && (interval != 0);
        iv    = longint'(interval);
        p     = m_period;
        tol   = p / 8;
        m_upd = 1'b0;
        m_ps  = 1'b0;
        if (rst) begin
            m_state = S_IDLE; m_period = INIT_P; m_edges = 0; m_good = 0; m_idle = 0;
        end else if (!enable) begin
            m_state = S_IDLE; m_edges = 0; m_good = 0; m_idle = 0;
        end else if (m_state == S_IDLE) begin
            m_state = S_ACQ; m_period = INIT_P; m_edges = 0; m_good = 0; m_idle = 0;
        end else if (ev) begin
            m_idle = 0;
            if (m_state == S_ACQ) begin
                if (iv < p) begin m_period = iv; m_upd = 1'b1; end
                m_edges++;
                if (m_edges == ACQ_N) begin m_state = S_TRACK; m_good = 0; end
            end else if (iv < p - tol) begin
                m_state = S_TRACK; m_period = iv; m_upd = 1'b1; m_good = 0;
            end else if (iv <= p + tol) begin
                m_ps = 1'b1;
                m_good++;
                if (m_good == LOCK_N) begin
                    m_good = 0;
                    if (m_state == S_TRACK) m_state = S_LOCK;
                    else begin
                        m_period = (p == PMAX) ? p : p + 1;
                        m_upd    = 1'b1;
                    end
                end
            end
        end else begin
            m_idle++;
            if (m_idle >= p * 16) begin
                m_state = S_ACQ; m_period = INIT_P; m_edges = 0; m_good = 0; m_idle = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_300M);
        model_step();
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk_300M);
        if (cmp_en) begin
            check("cyc_state", state, m_state);
            check("cyc_period", period, m_period);
            check("cyc_period_upd", period_upd, m_upd);
            check("cyc_phase_sync", phase_sync, m_ps);
            check("cyc_locked", locked, m_state == S_LOCK);
            if (period_upd) upd_cnt++;
            if (phase_sync) ps_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input int iv);
        edge_valid = 1'b1;
        interval   = iv;
        @(negedge clk_300M);
        edge_valid = 1'b0;
        interval   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_300M);
    endtask

    // From ACQ: four acquisition edges then eight consistent edges at period 100.
    task automatic reach_lock();
        repeat (ACQ_N) send(100);
        repeat (LOCK_N) send(100);
    endtask

    initial begin
        int base_upd, base_ps;
        rst = 1'b1; enable = 1'b0; edge_valid = 1'b0; interval = '0;
        idle(2);
        cmp_en = 1'b1;
        check("rst_state", state, 0);
        check("rst_period", period, 801);
        check("rst_locked", locked, 0);
        check("rst_period_upd", period_upd, 0);
        check("rst_phase_sync", phase_sync, 0);
        check("rst_model_period", m_period, 801);
        rst = 1'b0;
        idle(1);
        base_upd = upd_cnt; base_ps = ps_cnt;

        // Acquisition: 500, 300, 100, 100
        enable = 1'b1;
        idle(1);
        check("acq_entry_state", state, 1);
        send(500);
        check("acq_e1_period", period, 500);
        check("acq_e1_upd", period_upd, 1);
        send(300);
        send(100);
        check("acq_e3_period", period, 100);
        check("acq_e3_model_period", m_period, 100);
        send(100);
        check("acq_e4_state", state, 2);
        check("acq_e4_upd", period_upd, 0);
        idle(1);
        check("acq_upd_count", upd_cnt - base_upd, 3);
        check("acq_ps_count", ps_cnt - base_ps, 0);
        base_ps = ps_cnt;

        // Tracking: a long edge is neutral, then eight consistent edges lock
        send(113);
        check("trk_long_state", state, 2);
        check("trk_long_ps", phase_sync, 0);
        repeat (LOCK_N - 1) send(100);
        check("trk_7_locked", locked, 0);
        send(100);
        check("trk_8_locked", locked, 1);
        check("trk_8_state", state, 3);
        idle(1);
        check("trk_ps_count", ps_cnt - base_ps, 8);

        // Lock: 112 is in tolerance; eighth consistent edge probes period upward
        send(112);
        check("lock_112_ps", phase_sync, 1);
        check("lock_112_period", period, 100);
        repeat (LOCK_N - 1) send(100);
        check("lock_probe_period", period, 101);
        check("lock_probe_upd", period_upd, 1);
        check("lock_probe_model", m_period, 101);

        // Short edge in lock drops back to tracking
        send(80);
        check("lock_short_period", period, 80);
        check("lock_short_locked", locked, 0);
        check("lock_short_state", state, 2);

        // Re-acquire, lock at 100, then drop and restore enable
        enable = 1'b0; idle(1);
        enable = 1'b1; idle(1);
        reach_lock();
        check("relock_state", state, 3);
        check("relock_period", period, 100);
        enable = 1'b0;
        idle(1);
        check("dis_state", state, 0);
        check("dis_locked", locked, 0);
        check("dis_period", period, 100);
        enable = 1'b1;
        idle(1);
        check("reen_state", state, 1);
        check("reen_period", period, 801);
        reach_lock();

        // Loss of signal at period 100: limit is 1600 edge-free cycles
        idle(1598);
        send(100);
        check("to_saved_state", state, 3);
        idle(1599);
        check("to_1599_state", state, 3);
        idle(1);
        check("to_state", state, 1);
        check("to_period", period, 801);
        check("to_locked", locked, 0);

        // Zero interval is ignored in acquisition
        send(0);
        check("zero_state", state, 1);
        check("zero_period", period, 801);
        repeat (ACQ_N - 1) send(100);
        check("zero_acq3_state", state, 1);
        send(100);
        check("zero_acq4_state", state, 2);
        check("zero_acq4_period", period, 100);

        // Reset wins over a simultaneous edge
        rst = 1'b1; edge_valid = 1'b1; interval = 50;
        idle(1);
        check("rstedge_state", state, 0);
        check("rstedge_period", period, 801);
        check("rstedge_locked", locked, 0);
        check("rstedge_upd", period_upd, 0);
        check("rstedge_ps", phase_sync, 0);
        rst = 1'b0; edge_valid = 1'b0; interval = '0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_rec_ctrl.md
Name: clk_rec_ctrl

Overview:
- Sequencer for the bit-clock recovery datapath. Consumes per-edge interval measurements from the edge/interval counter and runs acquisition, tracking and lock supervision.
- Drives the bit period and phase-realign pulses into the recovered-clock NCO/divider. Reports lock status.
- Sits in the clk_300M_global domain, between the interval counter and the clock-out divider.

Parameters:
- W, 32, width of interval and period values
- INIT_PERIOD, 801, period loaded on reset and on every (re)acquisition
- ACQ_EDGES, 16, valid edges observed in ACQ before moving to TRACK
- LOCK_EDGES, 256, consecutive consistent edges needed for lock; also the LOCK probe interval
- TOL_SHIFT, 3, tolerance is period>>TOL_SHIFT
- TIMEOUT_SHIFT, 4, loss-of-signal limit is period<<TIMEOUT_SHIFT cycles without an edge

Ports:
- clk_300M  in  1  base clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  run control; low forces IDLE
- edge_valid  in  1  one-cycle pulse: a data edge was detected this cycle
- interval  in  W  measured interval in clk_300M cycles; valid when edge_valid=1
- period  out  W  current bit-period estimate to the NCO
- period_upd  out  1  one-cycle pulse: period changed on the previous edge
- phase_sync  out  1  one-cycle pulse: realign the NCO phase
- locked  out  1  high in the LOCK state only
- state  out  2  0=IDLE, 1=ACQ, 2=TRACK, 3=LOCK

Behaviour:
- Reset values: state=IDLE, period=INIT_PERIOD, period_upd=0, phase_sync=0, locked=0. Internal edge_cnt, good_cnt and idle_cnt are all 0.
- All outputs are registered. An edge sampled in cycle N affects outputs in cycle N+1.
- tol = period>>TOL_SHIFT.
- An edge is "consistent" when period-tol <= interval <= period+tol.
- An edge is "short" when interval < period-tol. Compare in W+1 bits; no wrap.
- interval=0 is ignored everywhere: not counted and does not reset idle_cnt.
- Priority, highest first: rst > enable=0 > edge_valid > timeout.
- IDLE:
  - enable=1 -> ACQ next cycle.
  - On entry to ACQ: period=INIT_PERIOD, edge_cnt=0, idle_cnt=0.
- ACQ:
  - On each edge: if interval < period, then period=interval and period_upd pulses.
  - edge_cnt increments on each edge. The edge that brings edge_cnt to ACQ_EDGES moves to TRACK, with good_cnt=0.
- TRACK:
  - Consistent edge: good_cnt+1 and phase_sync pulses.
  - Short edge: period=interval, good_cnt=0, period_upd pulses.
  - Long edge (a multi-bit run): no change to good_cnt or period.
  - good_cnt reaching LOCK_EDGES -> LOCK, locked=1, good_cnt=0.
- LOCK:
  - Consistent edge: phase_sync pulses and good_cnt+1.
  - When good_cnt reaches LOCK_EDGES: probe, period=period+1 (saturates at 2^W-1), period_upd pulses, good_cnt=0.
  - Short edge: period=interval, locked=0, good_cnt=0, go to TRACK, period_upd pulses.
- Timeout (ACQ/TRACK/LOCK):
  - idle_cnt increments every cycle with no valid edge. It saturates and clears on a valid edge.
  - When idle_cnt reaches period<<TIMEOUT_SHIFT (computed in W+TIMEOUT_SHIFT bits): go to ACQ, period=INIT_PERIOD, locked=0, and all counters clear.
  - A valid edge in the same cycle wins over timeout.
- enable dropping mid-operation: IDLE next cycle, locked=0, period holds its value, pulses are suppressed.
- rst mid-operation: all outputs return to reset values the next cycle; any in-flight edge is discarded.
- period_upd and phase_sync are never high for more than one consecutive cycle per edge.
- phase_sync never pulses in IDLE or ACQ.

Test Plan:
- Bench setup: ACQ_EDGES=4, LOCK_EDGES=8, INIT_PERIOD=801.
- Reset then enable=1, edges with intervals 500,300,100,100 -> period=100 one cycle after the 3rd edge; state=TRACK after the 4th; period_upd pulses on edges 1-3 only.
- In TRACK, period=100: 8 edges of interval 100 -> locked=1 one cycle after the 8th; phase_sync pulses 8 times. Interval 112 counts as consistent; interval 113 is long and leaves good_cnt unchanged.
- In LOCK: interval 80 -> period=80, locked=0, state=TRACK the next cycle. Separately, 8 more consistent edges of 100 -> period=101.
- In LOCK with period=100: no edges for 1600 cycles -> state=ACQ, period=801, locked=0. An edge at cycle 1599 prevents the timeout.
- Deassert enable while in LOCK -> state=IDLE, locked=0, period held at 100. Reassert -> ACQ with period=801.
- Assert rst together with edge_valid (interval=50) in TRACK -> all outputs at reset values and period=801, not 50.
